// File: rtl/df_sat_accum_if.sv
// Stream bundle for df_sat_accum: sample input, block result output and status.
// The master modport is the upstream/downstream side; the accumulator uses slave.
interface df_sat_accum_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8,
    parameter int CNT_W = 5
);
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic        [CNT_W-1:0] len;
    logic        [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sat;
    logic                    busy;

    modport master (
        output in_data, in_valid, len, out_ready,
        input  in_ready, out_data, out_valid, out_sat, busy
    );

    modport slave (
        input  in_data, in_valid, len, out_ready,
        output in_ready, out_data, out_valid, out_sat, busy
    );
endinterface

// File: rtl/df_sat_accum.sv
// Block accumulator: sums eff(len) signed samples, clamps the exact sum to OUT_W bits.
// Define DF_SAT_ACCUM_SIGNED_EN for a two's complement output range (default: unsigned clamp).
module df_sat_accum #(
    parameter int IN_W    = 9,
    parameter int OUT_W   = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input logic           clk,
    input logic           rst_n,
    df_sat_accum_if.slave bus
);
    localparam int ACC_W = IN_W + $clog2(MAX_LEN);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

    // Clamp bounds are one bit wider than the sum so the unsigned ceiling stays positive.
`ifdef DF_SAT_ACCUM_SIGNED_EN
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
`else
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W - OUT_W + 1){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic        [CNT_W-1:0] len_q;
    logic        [OUT_W-1:0] out_data_q;
    logic                    out_valid_q;
    logic                    out_sat_q;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum_next;
    logic signed [ACC_W:0]   sum_wide;
    logic        [CNT_W-1:0] len_eff;
    logic        [CNT_W-1:0] cnt_next;
    logic                    in_xfer;
    logic                    last_sample;
    logic        [OUT_W-1:0] clamp_data;
    logic                    clamp_sat;

    assign bus.in_ready  = (state != HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sat   = out_sat_q;

    assign in_xfer    = bus.in_valid && (state != HOLD);
    assign sample_ext = ACC_W'(bus.in_data);
    assign cnt_next   = cnt + LEN_ONE;
    assign sum_next   = (state == IDLE) ? sample_ext : (acc + sample_ext);
    assign sum_wide   = (ACC_W + 1)'(sum_next);

    // len is only honoured on the first sample of a block.
    always_comb begin
        if (bus.len == '0) begin
            len_eff = LEN_ONE;
        end else if (bus.len > LEN_MAX) begin
            len_eff = LEN_MAX;
        end else begin
            len_eff = bus.len;
        end
    end

    assign last_sample = (state == IDLE) ? (len_eff == LEN_ONE) : (cnt_next == len_q);

    always_comb begin
        clamp_data = sum_wide[OUT_W-1:0];
        clamp_sat  = 1'b0;
        if (sum_wide < SAT_LO) begin
            clamp_data = SAT_LO[OUT_W-1:0];
            clamp_sat  = 1'b1;
        end else if (sum_wide > SAT_HI) begin
            clamp_data = SAT_HI[OUT_W-1:0];
            clamp_sat  = 1'b1;
        end
    end

    // The result is registered on the last sample transfer so it appears with out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (in_xfer) begin
                        acc <= sum_next;
                        if (state == IDLE) begin
                            len_q <= len_eff;
                            cnt   <= LEN_ONE;
                        end else begin
                            cnt <= cnt_next;
                        end
                        if (last_sample) begin
                            state       <= HOLD;
                            out_data_q  <= clamp_data;
                            out_sat_q   <= clamp_sat;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    a_valid_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q == (state == HOLD));

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= len_q);
endmodule
